// File: rtl/mod_n_counter_arbiter.sv
// mod_n_counter_arbiter: one shared mod-N counter, lent round-robin to up to R requesters.
// The owner gets one full period from 0 to len-1. It then receives a one-cycle done pulse,
// and the block re-arbitrates.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   req    per-requester request level, held until done
//   len    per-requester modulus, requester i uses len[i*W +: W]
//   grant  one-hot owner of the counter, zero when not running
//   q      current count of the shared counter
//   busy   high while running or signalling completion
//   done   one-cycle completion pulse to the owner
module mod_n_counter_arbiter #(
  parameter int unsigned R = 4,
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req,
  input  logic [R*W-1:0] len,
  output logic [R-1:0]   grant,
  output logic [W-1:0]   q,
  output logic           busy,
  output logic [R-1:0]   done
);

  localparam int unsigned IW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [W-1:0]    n_q, n_d;
  logic [W-1:0]    cnt_q, cnt_d;
  logic [R-1:0]    grant_q, grant_d;
  logic [R-1:0]    done_q, done_d;

  logic            sel_valid;
  logic [IW-1:0]   sel_idx;
  logic [W-1:0]    sel_len;

  // Index arithmetic modulo R (R need not be a power of two).
  function automatic logic [IW-1:0] wrap_add(logic [IW-1:0] a, int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    if (s >= R) s = s - R;
    return IW'(s);
  endfunction

  // Round-robin pick: first set request scanning from rr_q upwards.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < R; i++) begin
      if (!sel_valid && req[wrap_add(rr_q, i)]) begin
        sel_valid = 1'b1;
        sel_idx   = wrap_add(rr_q, i);
      end
    end
    sel_len = len[32'(sel_idx)*W +: W];
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    done_d  = '0;
    unique case (state_q)
      StIdle: begin
        grant_d = '0;
        cnt_d   = '0;
        if (sel_valid) begin
          state_d = StRun;
          owner_d = sel_idx;
          // A zero modulus behaves as a single-cycle period.
          n_d     = (sel_len == '0) ? W'(1) : sel_len;
          grant_d = R'(1) << sel_idx;
          rr_d    = wrap_add(sel_idx, 1);
        end
      end
      StRun: begin
        // Abort wins over completion on the same edge.
        if (!req[owner_q]) begin
          state_d = StIdle;
          cnt_d   = '0;
          grant_d = '0;
        end else if (cnt_q == n_q - W'(1)) begin
          state_d = StDone;
          cnt_d   = '0;
          grant_d = '0;
          done_d  = R'(1) << owner_q;
        end else begin
          cnt_d = cnt_q + W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        grant_d = '0;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      rr_q    <= '0;
      n_q     <= W'(1);
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
    end
  end

  assign grant = grant_q;
  assign q     = cnt_q;
  assign busy  = (state_q != StIdle);
  assign done  = done_q;

endmodule

// File: tb/tb_mod_n_counter_arbiter.sv
module tb_mod_n_counter_arbiter;

  localparam int unsigned R = 4;
  localparam int unsigned W = 4;

  logic           clk;
  logic           rst;
  logic [R-1:0]   req;
  logic [R*W-1:0] len;
  logic [R-1:0]   grant;
  logic [W-1:0]   q;
  logic           busy;
  logic [R-1:0]   done;

  int unsigned n_checks;
  int unsigned n_errors;

  mod_n_counter_arbiter #(.R(R), .W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .len   (len),
    .grant (grant),
    .q     (q),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int unsigned g, input int unsigned qq,
                           input int unsigned b, input int unsigned d);
    check({tag, ".grant"}, 32'(grant), g);
    check({tag, ".q"}, 32'(q), qq);
    check({tag, ".busy"}, 32'(busy), b);
    check({tag, ".done"}, 32'(done), d);
  endtask

  // Synchronous-looking reset pulse spanning one clock edge, released after it.
  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    req = '0;
    len = '0;
    #2;

    // Reset values with random requests applied.
    rst = 1'b0;
    req = R'($urandom);
    len = (R*W)'($urandom);
    tick();
    tick();
    check_out("rst_hold", 0, 0, 0, 0);
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    check_out("rst_rel", 0, 0, 0, 0);

    // Single requester, modulus 6.
    req = 4'b0001;
    len = 16'h0006;
    tick();
    check_out("single.e0", 1, 0, 1, 0);
    for (int k = 1; k < 6; k++) begin
      tick();
      check("single.q", 32'(q), k);
      check("single.g", 32'(grant), 1);
    end
    tick();
    check_out("single.done", 0, 0, 1, 1);
    tick();
    check_out("single.idle", 0, 0, 0, 0);
    tick();
    check_out("single.regrant", 1, 0, 1, 0);
    req = '0;
    tick();
    check_out("single.drop", 0, 0, 0, 0);

    // Round-robin with all four requesting, modulus 3.
    do_reset();
    req = 4'b1111;
    len = 16'h3333;
    for (int g = 0; g < 5; g++) begin
      tick();
      check_out("rr.grant", 32'(1) << (g % 4), 0, 1, 0);
      tick();
      tick();
      check("rr.q2", 32'(q), 2);
      tick();
      check_out("rr.done", 0, 0, 1, 32'(1) << (g % 4));
      tick();
      check_out("rr.idle", 0, 0, 0, 0);
    end

    // Zero modulus acts as one.
    do_reset();
    req = 4'b0100;
    len = 16'h0000;
    tick();
    check_out("len0.grant", 4, 0, 1, 0);
    tick();
    check_out("len0.done", 0, 0, 1, 4);
    tick();
    check_out("len0.idle", 0, 0, 0, 0);

    // Abort by the owner, pending requester served next.
    do_reset();
    req = 4'b1010;
    len = 16'h2060;
    tick();
    check_out("abort.grant", 2, 0, 1, 0);
    tick();
    tick();
    check_out("abort.q2", 2, 2, 1, 0);
    req = 4'b1000;
    tick();
    check_out("abort.idle", 0, 0, 0, 0);
    tick();
    check_out("abort.next", 8, 0, 1, 0);

    // Asynchronous reset in the middle of a period.
    do_reset();
    req = 4'b0001;
    len = 16'h0006;
    tick();
    tick();
    tick();
    tick();
    tick();
    check_out("areset.q4", 1, 4, 1, 0);
    req = 4'b0011;
    #2;
    rst = 1'b0;
    #1;
    check_out("areset.clear", 0, 0, 0, 0);
    tick();
    check_out("areset.hold", 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    check_out("areset.restart", 1, 0, 1, 0);
    tick();
    check("areset.q1", 32'(q), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
